// File: rtl/eff_bypass_ctrl_pkg.sv
// Shared types, defaults and the crossfade arithmetic for the effect bypass controller.
// The mix helper is width-generic so every effect stage can reuse it.
package eff_pkg;

  typedef enum logic [1:0] {BYPASS, FADE_IN, ACTIVE, FADE_OUT} bypass_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

  // Floor of the weighted sum; the result never exceeds max(wet, dry), so truncating is safe.
  function automatic logic [31:0] mixSample(input logic [31:0] wet,
                                            input logic [31:0] dry,
                                            input logic [31:0] g,
                                            input int unsigned shift);
    logic [63:0] acc;
    acc = 64'(wet) * 64'(g) + 64'(dry) * ((64'd1 << shift) - 64'(g));
    return 32'(acc >> shift);
  endfunction

endpackage

// File: rtl/eff_bypass_ctrl_if.sv
// Sample streams and status between the pedal chain, one effect stage and its bypass controller.
// The controller takes the slave view; whatever drives samples takes the master view.
interface eff_bypass_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  vld_i;
  logic                  eff_en_o;
  logic [DATA_WIDTH-1:0] eff_data_o;
  logic                  eff_vld_o;
  logic [DATA_WIDTH-1:0] eff_data_i;
  logic                  eff_vld_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  vld_o;
  logic                  active_o;
  logic                  ovf_o;
  logic                  unf_o;

  modport slave (
    input  data_i, vld_i, eff_data_i, eff_vld_i,
    output eff_en_o, eff_data_o, eff_vld_o, data_o, vld_o, active_o, ovf_o, unf_o
  );

  modport master (
    output data_i, vld_i, eff_data_i, eff_vld_i,
    input  eff_en_o, eff_data_o, eff_vld_o, data_o, vld_o, active_o, ovf_o, unf_o
  );
endinterface

// File: rtl/eff_bypass_ctrl_debounce.sv
// Footswitch conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
// Shared by every footswitch input on the pedal.
module btn_debounce #(
  parameter int unsigned CYCLES = eff_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q;
  logic          rise_q;
  logic          change;
  logic          stable;

  // A difference between the two sync stages means the level is about to change.
  assign change = sync_q[0] ^ sync_q[1];
  assign stable = (cnt_q == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      rise_q <= 1'b0;
      if (change) begin
        cnt_q <= '0;
      end else if (!stable) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        lvl_q  <= sync_q[1];
        rise_q <= sync_q[1] & ~lvl_q;
      end
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/eff_bypass_ctrl.sv
// Click-free bypass for one effect stage: keeps the dry copy aligned with the wet return
// and crossfades between them over 2^RAMP_SHIFT samples on every footswitch press.
module eff_bypass_ctrl
  import eff_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RAMP_SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  input logic              btn_i,
  eff_bypass_ctrl_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned GW = RAMP_SHIFT + 1;
  localparam logic [GW-1:0] G_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};

  logic                  btnLvl;
  logic                  btnRise;
  logic                  toggle;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q, rdPtr_q;
  logic [AW:0]           count_q;
  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] mixVal;
  logic [DATA_WIDTH-1:0] effData_q, data_q;
  logic                  effVld_q, vld_q, ovf_q, unf_q;
  bypass_state_t         state_q;
  logic [GW-1:0]         g_q, g_d;
  logic                  effEn_q, active_q;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_i),
    .lvl_o  (btnLvl),
    .rise_o (btnRise)
  );

  assign toggle = btnRise & btnLvl;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = bus.eff_vld_i & ~empty;
  assign push  = bus.vld_i & (~full | pop);
  assign drop  = bus.vld_i & full & ~pop;

  assign mixVal = DATA_WIDTH'(mixSample(32'(bus.eff_data_i), 32'(mem_q[rdPtr_q]),
                                        32'(g_q), RAMP_SHIFT));

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= bus.data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      effData_q <= '0;
      effVld_q  <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      effVld_q <= push;
      vld_q    <= pop;
      ovf_q    <= ovf_q | drop;
      unf_q    <= unf_q | (bus.eff_vld_i & empty);
      if (push) begin
        wrPtr_q   <= wrPtr_q + 1'b1;
        effData_q <= bus.data_i;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
        data_q  <= mixVal;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Gain moves one step per output sample and saturates at its end of the ramp.
  always_comb begin
    g_d = g_q;
    case (state_q)
      FADE_IN:  if (pop && g_q != G_FULL) g_d = g_q + 1'b1;
      FADE_OUT: if (pop && g_q != '0)     g_d = g_q - 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BYPASS;
      g_q      <= '0;
      effEn_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      g_q      <= g_d;
      effEn_q  <= (state_q != BYPASS);
      active_q <= (state_q == FADE_IN) || (state_q == ACTIVE);
      case (state_q)
        BYPASS:   if (toggle) state_q <= FADE_IN;
        FADE_IN:  if (toggle) state_q <= FADE_OUT;
                  else if (g_d == G_FULL) state_q <= ACTIVE;
        ACTIVE:   if (toggle) state_q <= FADE_OUT;
        FADE_OUT: if (toggle) state_q <= FADE_IN;
                  else if (g_d == '0) state_q <= BYPASS;
        default:  state_q <= BYPASS;
      endcase
    end
  end

  assign bus.eff_en_o   = effEn_q;
  assign bus.eff_data_o = effData_q;
  assign bus.eff_vld_o  = effVld_q;
  assign bus.data_o     = data_q;
  assign bus.vld_o      = vld_q;
  assign bus.active_o   = active_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.unf_o      = unf_q;
endmodule

// File: tb/tb_eff_bypass_ctrl.sv
// Directed bench for eff_bypass_ctrl with a small in-order effect model (fixed return delay).
// Expected samples are hand-computed crossfade values for RAMP_SHIFT=2.
module tb_eff_bypass_ctrl;
  localparam int unsigned DW  = 12;
  localparam int unsigned DEB = 16;
  localparam int unsigned RS  = 2;
  localparam int unsigned FD  = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            readyCyc;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  eff_bypass_ctrl_if #(.DATA_WIDTH(DW)) bus();

  eff_bypass_ctrl #(
    .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(DEB), .RAMP_SHIFT(RS), .FIFO_DEPTH(FD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  pend_t       pendQ[$];
  logic [31:0] outQ[$];
  logic [31:0] fwdLog[$];
  int          cyc = 0, effVldCnt = 0, latErr = 0, enErr = 0;
  int          assertCount = 0, failCount = 0;
  bit          latChk = 0, enChk = 0, holdRet = 0, wetConstEn = 0;
  logic [DW-1:0] wetConst = '0;
  logic        prevDrive = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the world: capture outputs, then let the effect model decide its return.
  task automatic tick();
    pend_t p;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.vld_o === 1'b1) outQ.push_back(32'(bus.data_o));
    if (latChk && bus.vld_o !== prevDrive) latErr++;
    if (enChk && bus.eff_en_o !== 1'b0) enErr++;
    if (bus.eff_vld_o === 1'b1) begin
      effVldCnt++;
      fwdLog.push_back(32'(bus.eff_data_o));
      p.data     = bus.eff_data_o;
      p.readyCyc = cyc + 3;
      pendQ.push_back(p);
    end
    bus.eff_vld_i = 1'b0;
    if (!holdRet && pendQ.size() > 0 && pendQ[0].readyCyc <= cyc) begin
      p = pendQ.pop_front();
      bus.eff_vld_i  = 1'b1;
      bus.eff_data_i = wetConstEn ? wetConst : p.data + 12'd100;
    end
    prevDrive = bus.eff_vld_i;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d);
    bus.data_i = d;
    bus.vld_i  = 1'b1;
    tick();
    bus.vld_i  = 1'b0;
  endtask

  task automatic waitOutput(input string tag, input logic [31:0] exp);
    int n = 0;
    while (outQ.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    if (outQ.size() == 0) checkOutput({tag, " timeout"}, 32'(outQ.size()), 1);
    else checkOutput(tag, outQ.pop_front(), exp);
  endtask

  task automatic setButton(input logic lvl);
    btn = lvl;
    repeat (25) tick();
  endtask

  logic [31:0] fadeInExp [6];
  logic [31:0] fadeOutExp [5];
  int          n, bounceErr;

  initial begin
    fadeInExp  = '{1000, 1250, 1500, 1750, 2000, 2000};
    fadeOutExp = '{2000, 1750, 1500, 1250, 1000};
    bus.data_i = '0; bus.vld_i = 1'b0; bus.eff_data_i = '0; bus.eff_vld_i = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    checkOutput("reset vld_o", bus.vld_o, 0);
    checkOutput("reset data_o", bus.data_o, 0);
    checkOutput("reset eff_vld_o", bus.eff_vld_o, 0);
    checkOutput("reset eff_data_o", bus.eff_data_o, 0);
    checkOutput("reset eff_en_o", bus.eff_en_o, 0);
    checkOutput("reset active_o", bus.active_o, 0);
    checkOutput("reset ovf_o", bus.ovf_o, 0);
    checkOutput("reset unf_o", bus.unf_o, 0);
    rst = 1'b1;
    repeat (20) tick();

    // Bypass: output is the dry sample even though the wet return differs.
    latChk = 1; enChk = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(DW'(100 + 37 * i));
      tick();
    end
    for (int i = 0; i < 8; i++) waitOutput("bypass data", 32'(100 + 37 * i));
    repeat (6) tick();
    latChk = 0; enChk = 0;
    checkOutput("bypass latency", latErr, 0);
    checkOutput("bypass eff_en_o", enErr, 0);
    checkOutput("bypass fwd count", effVldCnt, 8);
    checkOutput("fwd log size", 32'(fwdLog.size()), 8);
    checkOutput("fwd data first", fwdLog[0], 100);
    checkOutput("fwd data sixth", fwdLog[5], 285);

    wetConstEn = 1; wetConst = 12'd2000;
    bounceErr = 0;
    for (int i = 0; i < 40; i++) begin
      btn = ~btn;
      repeat (5) begin
        tick();
        if (bus.active_o !== 1'b0) bounceErr++;
      end
    end
    checkOutput("bounce rejected", bounceErr, 0);
    btn = 1'b1;
    n = 0;
    while (bus.active_o !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("debounce delay", n, 20);
    repeat (30) tick();
    checkOutput("single toggle active_o", bus.active_o, 1);
    checkOutput("fade-in eff_en_o", bus.eff_en_o, 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(12'd1000);
      waitOutput("fade-in data", fadeInExp[i]);
    end
    checkOutput("active after ramp", bus.active_o, 1);
    setButton(1'b0);
    setButton(1'b1);
    checkOutput("fade-out active_o", bus.active_o, 0);
    checkOutput("fade-out eff_en_o", bus.eff_en_o, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(12'd1000);
      waitOutput("fade-out data", fadeOutExp[i]);
    end
    setButton(1'b0);
    checkOutput("bypass after fade-out", bus.eff_en_o, 0);

    // Reverse the fade after two samples; the ramp retraces from g=2.
    setButton(1'b1);
    applyStimulus(12'd1000);
    waitOutput("rev fade-in 0", 1000);
    applyStimulus(12'd1000);
    waitOutput("rev fade-in 1", 1250);
    setButton(1'b0);
    setButton(1'b1);
    checkOutput("rev active_o", bus.active_o, 0);
    applyStimulus(12'd1000);
    waitOutput("rev out 0", 1500);
    applyStimulus(12'd1000);
    waitOutput("rev out 1", 1250);
    checkOutput("eff_en_o at last fade", bus.eff_en_o, 1);
    tick();
    checkOutput("eff_en_o one later", bus.eff_en_o, 0);
    applyStimulus(12'd1000);
    waitOutput("rev out 2", 1000);
    setButton(1'b0);

    wetConstEn = 0; holdRet = 1; effVldCnt = 0;
    for (int i = 0; i < 5; i++) applyStimulus(DW'(300 + i));
    repeat (3) tick();
    checkOutput("ovf fwd count", effVldCnt, 4);
    checkOutput("ovf_o set", bus.ovf_o, 1);
    checkOutput("unf_o clear", bus.unf_o, 0);
    holdRet = 0;
    for (int i = 0; i < 4; i++) waitOutput("drain data", 32'(300 + i));
    repeat (5) tick();
    bus.eff_vld_i = 1'b1; bus.eff_data_i = 12'd555;
    tick();
    checkOutput("spurious no vld_o", bus.vld_o, 0);
    checkOutput("unf_o set", bus.unf_o, 1);
    checkOutput("ovf_o sticky", bus.ovf_o, 1);

    applyStimulus(12'd400);
    tick();
    applyStimulus(12'd401);
    #2 rst = 1'b0;
    #1;
    checkOutput("async rst eff_vld_o", bus.eff_vld_o, 0);
    checkOutput("async rst data_o", bus.data_o, 0);
    checkOutput("async rst ovf_o", bus.ovf_o, 0);
    checkOutput("async rst unf_o", bus.unf_o, 0);
    checkOutput("async rst eff_en_o", bus.eff_en_o, 0);
    pendQ.delete();
    outQ.delete();
    bus.eff_vld_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    checkOutput("no vld_o after reset", 32'(outQ.size()), 0);
    applyStimulus(12'd777);
    waitOutput("post-reset data", 777);
    checkOutput("post-reset unf_o", bus.unf_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
